// File: rtl/rng_pkg.sv
// Shared definitions for the RNG sequencing controller: FSM encoding,
// RNG slave register offsets and AXI response codes.
package rng_pkg;

  typedef enum logic [3:0] {
    IDLE,
    SEED_W,
    SEED_B,
    RD_AR,
    RD_R,
    OUT,
    CNT_AR,
    CNT_R,
    DONE
  } state_t;

  localparam logic [31:0] OFF_RNG  = 32'h0000_0000;
  localparam logic [31:0] OFF_SEED = 32'h0000_0008;
  localparam logic [31:0] OFF_CNT  = 32'h0000_000C;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/rng_seq_ctrl.sv
// AXI master that seeds an RNG slave, streams a requested number of random
// words to a ready/valid consumer, then reads back the slave's word counter.
module rng_seq_ctrl
  import rng_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [15:0] AXI_ID    = 16'h0001
) (
  input  logic        ACLK,
  input  logic        ARESETn,
  input  logic        start,
  input  logic [31:0] seed_in,
  input  logic [7:0]  count_in,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [31:0] rd_count,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] AWID,
  output logic [31:0] AWADDR,
  output logic [3:0]  AWLEN,
  output logic [2:0]  AWSIZE,
  output logic [1:0]  AWBURST,
  output logic        AWVALID,
  input  logic        AWREADY,
  output logic [31:0] WDATA,
  output logic [7:0]  WSTRB,
  output logic        WVALID,
  input  logic        WREADY,
  input  logic [15:0] BID,
  input  logic [1:0]  BRESP,
  input  logic        BVALID,
  output logic        BREADY,
  output logic [15:0] ARID,
  output logic [31:0] ARADDR,
  output logic [3:0]  ARLEN,
  output logic [2:0]  ARSIZE,
  output logic [1:0]  ARBURST,
  output logic        ARVALID,
  input  logic        ARREADY,
  input  logic [15:0] RID,
  input  logic [31:0] RDATA,
  input  logic [1:0]  RRESP,
  input  logic        RLAST,
  input  logic        RVALID,
  output logic        RREADY
);

  state_t      state, state_d;
  logic [31:0] seed_q;
  logic [7:0]  remain;
  logic        aw_done, w_done;
  logic        aw_fin, w_fin;
  logic        b_bad, r_bad;

  assign AWID    = AXI_ID;
  assign ARID    = AXI_ID;
  assign AWLEN   = 4'd0;
  assign ARLEN   = 4'd0;
  assign AWSIZE  = 3'b010;
  assign ARSIZE  = 3'b010;
  assign AWBURST = 2'b01;
  assign ARBURST = 2'b01;
  assign WSTRB   = 8'h0F;
  assign AWADDR  = BASE_ADDR + OFF_SEED;
  assign WDATA   = seed_q;

  // A channel counts as finished once its handshake has happened, including this cycle.
  assign aw_fin = aw_done | (AWVALID & AWREADY);
  assign w_fin  = w_done  | (WVALID  & WREADY);
  assign b_bad  = (BRESP != RESP_OKAY) || (BID != AXI_ID);
  assign r_bad  = (RRESP != RESP_OKAY) || (RID != AXI_ID) || !RLAST;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) state <= IDLE;
    else          state <= state_d;
  end

  always_comb begin
    state_d   = state;
    busy      = 1'b1;
    done      = 1'b0;
    out_valid = 1'b0;
    AWVALID   = 1'b0;
    WVALID    = 1'b0;
    BREADY    = 1'b0;
    ARVALID   = 1'b0;
    ARADDR    = BASE_ADDR + OFF_RNG;
    RREADY    = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_d = SEED_W;
      end
      SEED_W: begin
        AWVALID = !aw_done;
        WVALID  = !w_done;
        if (aw_fin && w_fin) state_d = SEED_B;
      end
      SEED_B: begin
        BREADY = 1'b1;
        if (BVALID) state_d = b_bad ? DONE : ((remain != 8'd0) ? RD_AR : CNT_AR);
      end
      RD_AR: begin
        ARVALID = 1'b1;
        if (ARREADY) state_d = RD_R;
      end
      RD_R: begin
        RREADY = 1'b1;
        if (RVALID) state_d = r_bad ? DONE : OUT;
      end
      OUT: begin
        out_valid = 1'b1;
        // remain is at least one here, so more words are due only if it exceeds one
        if (out_ready) state_d = (remain > 8'd1) ? RD_AR : CNT_AR;
      end
      CNT_AR: begin
        ARVALID = 1'b1;
        ARADDR  = BASE_ADDR + OFF_CNT;
        if (ARREADY) state_d = CNT_R;
      end
      CNT_R: begin
        RREADY = 1'b1;
        if (RVALID) state_d = DONE;
      end
      DONE: begin
        busy    = 1'b0;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        busy    = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      seed_q   <= 32'd0;
      remain   <= 8'd0;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
      error    <= 1'b0;
      out_data <= 32'd0;
      rd_count <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            seed_q  <= seed_in;
            remain  <= count_in;
            error   <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
          end
        end
        SEED_W: begin
          if (AWVALID && AWREADY) aw_done <= 1'b1;
          if (WVALID && WREADY)   w_done  <= 1'b1;
        end
        SEED_B: begin
          if (BVALID && b_bad) error <= 1'b1;
        end
        RD_R: begin
          // A bad beat is dropped so the consumer never sees it.
          if (RVALID) begin
            if (r_bad) error    <= 1'b1;
            else       out_data <= RDATA;
          end
        end
        OUT: begin
          if (out_ready && remain != 8'd0) remain <= remain - 8'd1;
        end
        CNT_R: begin
          if (RVALID) begin
            if (r_bad) error    <= 1'b1;
            else       rd_count <= RDATA;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
